latch_loader: RTL and testbench
===============================

LATCH_LOADER -- requirements
Module: latch_loader

Interface
REQ-001 Parameter WIDTH, default 8, shall set the word width of the latch bank being loaded; legal range 2..32.
REQ-002 Parameter STROBE_CYCLES, default 2, shall set the number of cycles e is held high; legal range 1..15.
REQ-003 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  shall be the reset: synchronous, active-low.
REQ-005 sin  input  1  shall carry serial data, LSB first.
REQ-006 sin_valid  input  1  shall qualify sin; a bit is accepted when sin_valid and sin_ready are both 1 at a rising edge.
REQ-007 sin_ready  output  1  shall indicate the block accepts serial bits.
REQ-008 d  output  WIDTH  shall be the data word for the downstream D-latch bank.
REQ-009 e  output  1  shall be the shared enable for the downstream D-latch bank.
REQ-010 done  output  1  shall pulse high for one cycle per completed load.
REQ-011 overrun  output  1  shall be a sticky flag for bits offered while not ready.

Function
REQ-012 The FSM shall have exactly four states: IDLE, SETUP, STROBE, HOLD.
REQ-013 IDLE: sin_ready=1, e=0; each accepted bit shall shift into bit position (count) of an internal word; count increments by 1.
REQ-014 Acceptance of the WIDTH-th bit shall clear count to 0, transfer the assembled word to d and move to SETUP on the same edge.
REQ-015 SETUP: one cycle; d stable, e=0, sin_ready=0; next state STROBE.
REQ-016 STROBE: e=1 for exactly STROBE_CYCLES consecutive cycles, d unchanged; then HOLD.
REQ-017 HOLD: one cycle; e=0, d unchanged, done=1; next state IDLE.
REQ-018 Latency: last bit accepted at edge T gives SETUP during cycle T+1, e=1 during T+2..T+1+STROBE_CYCLES, done during T+2+STROBE_CYCLES, sin_ready=1 from T+3+STROBE_CYCLES.
REQ-019 d shall change only on the transition into SETUP and shall retain its value in IDLE; e and d shall never change on the same edge.
REQ-020 sin_valid=1 while sin_ready=0 shall drop the bit (no shift, no count change) and set overrun to 1; overrun shall stay 1 until reset.
REQ-021 sin_valid=0 in IDLE shall hold count and partial word indefinitely; no timeout.
REQ-022 The strobe counter shall be width 4 and count down from STROBE_CYCLES-1 to 0; no wrap beyond 0.
REQ-023 done and e shall never be high in the same cycle.

Reset
REQ-024 rst_n=0 at a rising edge shall force: state IDLE, count 0, partial word 0, d 0, e 0, done 0, overrun 0, sin_ready 1 from the next cycle.
REQ-025 Reset during SETUP/STROBE/HOLD shall abort the load: e low from the next edge, no done pulse, partial bits discarded.
REQ-026 Reset shall take priority over all other inputs including simultaneous sin_valid.

Structure
REQ-027 State encodings (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, HOLD=2'd3) and the default WIDTH/STROBE_CYCLES values shall reside in shared package latch_pkg.
REQ-028 The serial-in shift register with its bit counter shall be a sub-module named sipo_reg (ports clk, rst_n, sin, shift_en, word, full).
REQ-029 All outputs shall be registered; no combinational path from sin/sin_valid to any output except sin_ready, which is decoded from state only.

Verification
REQ-030 Reset then 8 bits 1,0,1,1,0,0,1,0 with sin_valid=1 continuously -> d=8'h4D in SETUP, e high exactly 2 cycles, done 1 cycle, overrun=0.
REQ-031 Same word with sin_valid toggling 1,0,1,0... -> identical d=8'h4D and timing relative to the last accepted bit.
REQ-032 sin_valid held 1 across the full load of 8'hFF then 8'h00 -> bits during SETUP..HOLD dropped, overrun=1, second word loaded starting at first IDLE cycle.
REQ-033 rst_n=0 on the 2nd cycle of STROBE -> e=0 next cycle, d=0, no done, sin_ready=1 after reset release.
REQ-034 WIDTH=4, STROBE_CYCLES=1, bits 1,1,0,1 -> d=4'hB, e high exactly 1 cycle, done at T+3.
REQ-035 Checker on every run: e and done never both 1; d never changes while e=1 or on the edge e changes.

Source files
------------

// File: rtl/latch_pkg.sv
// latch_pkg: shared definitions for the latch loader slice.
//   state_e            - loader FSM state encoding (IDLE/SETUP/STROBE/HOLD)
//   DEF_WIDTH          - default word width of the downstream latch bank
//   DEF_STROBE_CYCLES  - default number of cycles the enable is held high
package latch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_STROBE_CYCLES = 2;

endpackage

// File: rtl/latch_loader_sipo_reg.sv
// sipo_reg: serial-in parallel-out word assembler, LSB first.
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   sin      in   serial data bit
//   shift_en in   store sin at the current bit position this cycle
//   word     out  assembled word including the bit currently on sin
//   full     out  the bit position being written is the last one (WIDTH-1)
// When a bit is stored while full is high the counter and the partial word
// both return to zero, ready for the next word; the caller captures word on
// that same edge.
module sipo_reg
  import latch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             shift_en,
  output logic [WIDTH-1:0] word,
  output logic             full
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] word_q, word_d;

  assign full = (count_q == CW'(WIDTH - 1));

  // Partial word with the incoming bit merged in, so the last bit is visible
  // to the caller on the edge it is accepted.
  always_comb begin
    word          = word_q;
    word[count_q] = sin;
  end

  // Next-state for the bit counter and partial word.
  always_comb begin
    count_d = count_q;
    word_d  = word_q;
    if (shift_en) begin
      if (full) begin
        count_d = '0;
        word_d  = '0;
      end else begin
        count_d = count_q + CW'(1);
        word_d  = word;
      end
    end else begin
      count_d = count_q;
      word_d  = word_q;
    end
  end

  // Counter and partial-word registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      word_q  <= '0;
    end else begin
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: rtl/latch_loader.sv
// latch_loader: shifts a serial word in, then drives a D-latch bank with a
// setup / strobe / hold sequence.
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   sin       in   serial data, LSB first
//   sin_valid in   sin qualifier
//   sin_ready out  block accepts serial bits (decoded from state only)
//   d         out  WIDTH-bit data word for the latch bank
//   e         out  shared latch enable, high for STROBE_CYCLES cycles
//   done      out  one-cycle pulse per completed load
//   overrun   out  sticky: a bit was offered while not ready
module latch_loader
  import latch_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [WIDTH-1:0] d,
  output logic             e,
  output logic             done,
  output logic             overrun
);

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       scnt_q, scnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             e_q, done_q, overrun_q, overrun_d;
  logic             accept_s, full_s;
  logic [WIDTH-1:0] word_s;

  assign sin_ready = (state_q == IDLE);
  assign accept_s  = sin_valid & sin_ready;
  assign d         = d_q;
  assign e         = e_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

  sipo_reg #(
    .WIDTH (WIDTH)
  ) u_sipo (
    .clk      (clk),
    .rst_n    (rst_n),
    .sin      (sin),
    .shift_en (accept_s),
    .word     (word_s),
    .full     (full_s)
  );

  // FSM next state, strobe countdown, latch data capture and overrun flag.
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    d_d       = d_q;
    overrun_d = overrun_q | (sin_valid & ~sin_ready);
    case (state_q)
      IDLE: begin
        if (accept_s && full_s) begin
          d_d     = word_s;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        scnt_d  = STROBE_LAST;
        state_d = STROBE;
      end
      STROBE: begin
        // Count down to zero and stop; leaving STROBE ends the countdown.
        if (scnt_q == 4'd0) begin
          state_d = HOLD;
        end else begin
          scnt_d = scnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; e and done are decoded from the next state so
  // they line up with STROBE and HOLD without a combinational output path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      scnt_q    <= 4'd0;
      d_q       <= '0;
      e_q       <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      d_q       <= d_d;
      e_q       <= (state_d == STROBE);
      done_q    <= (state_d == HOLD);
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_latch_loader.sv
// tb_latch_loader: directed self-checking bench for latch_loader.
// Instance A uses the default parameters (8-bit, 2-cycle strobe); instance B
// uses WIDTH=4, STROBE_CYCLES=1. Inputs change 1 ns after the rising edge and
// outputs are sampled there too; a negedge monitor checks e/done exclusion
// and d stability around e on both instances every cycle.
module tb_latch_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sin_a = 1'b0, valid_a = 1'b0;
  logic       sin_b = 1'b0, valid_b = 1'b0;
  logic       sin_ready_a, e_a, done_a, overrun_a;
  logic [7:0] d_a;
  logic       sin_ready_b, e_b, done_b, overrun_b;
  logic [3:0] d_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  latch_loader dut_a (
    .clk(clk), .rst_n(rst_n), .sin(sin_a), .sin_valid(valid_a),
    .sin_ready(sin_ready_a), .d(d_a), .e(e_a), .done(done_a), .overrun(overrun_a)
  );

  latch_loader #(.WIDTH(4), .STROBE_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .sin(sin_b), .sin_valid(valid_b),
    .sin_ready(sin_ready_b), .d(d_b), .e(e_b), .done(done_b), .overrun(overrun_b)
  );

  // Continuous monitor: e/done exclusion, d frozen while e is (or was) high.
  logic       chk_en = 1'b0;
  logic       rst_prev = 1'b0;
  logic       e_a_prev = 1'b0, e_b_prev = 1'b0;
  logic [7:0] d_a_prev = 8'h00;
  logic [3:0] d_b_prev = 4'h0;

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ((e_a && done_a) || (e_b && done_b)) begin
        bad++;
        $display("FAIL excl: e_a=%b done_a=%b e_b=%b done_b=%b, required never both 1",
                 e_a, done_a, e_b, done_b);
      end
      if (rst_prev) begin
        total++;
        if (((d_a !== d_a_prev) && (e_a || e_a_prev)) ||
            ((d_b !== d_b_prev) && (e_b || e_b_prev))) begin
          bad++;
          $display("FAIL d_stable: d_a %h->%h e_a %b->%b, d_b %h->%h e_b %b->%b, required d unchanged around e",
                   d_a_prev, d_a, e_a_prev, e_a, d_b_prev, d_b, e_b_prev, e_b);
        end
      end
    end
    rst_prev = rst_n;
    e_a_prev = e_a;
    e_b_prev = e_b;
    d_a_prev = d_a;
    d_b_prev = d_b;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: shift a byte into A, LSB first; gaps inserts an invalid
  // cycle (with inverted garbage on sin) after every bit but the last.
  task automatic shift_a(input logic [7:0] w, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      sin_a   = w[i];
      valid_a = 1'b1;
      tick();
      if (gaps && i < 7) begin
        valid_a = 1'b0;
        sin_a   = ~w[i];
        tick();
      end
    end
    valid_a = 1'b0;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    valid_a = 1'b1;
    sin_a   = 1'b1;
    valid_b = 1'b1;
    sin_b   = 1'b1;
    tick();
    tick();
    total++;
    if (sin_ready_a !== 1'b1 || d_a !== 8'h00 || e_a !== 1'b0 || done_a !== 1'b0 || overrun_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_a: rdy=%b d=%h e=%b done=%b ovr=%b, required 1 00 0 0 0",
               sin_ready_a, d_a, e_a, done_a, overrun_a);
    end
    total++;
    if (sin_ready_b !== 1'b1 || d_b !== 4'h0 || e_b !== 1'b0 || done_b !== 1'b0 || overrun_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_b: rdy=%b d=%h e=%b done=%b ovr=%b, required 1 0 0 0 0",
               sin_ready_b, d_b, e_b, done_b, overrun_b);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    sin_a   = 1'b0;
    sin_b   = 1'b0;
    rst_n   = 1'b1;
    tick();
    chk_en = 1'b1;
  endtask

  task automatic test_basic;
    logic [7:0] w;
    w = 8'h4D;
    shift_a(w, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      total++;
      if (d_a !== w || e_a !== (c == 2 || c == 3) || done_a !== (c == 4) || sin_ready_a !== (c == 5)) begin
        bad++;
        $display("FAIL basic_seq T+%0d: d=%h e=%b done=%b rdy=%b, required d=%h e=%b done=%b rdy=%b",
                 c, d_a, e_a, done_a, sin_ready_a, w, (c == 2 || c == 3), (c == 4), (c == 5));
      end
      tick();
    end
    total++;
    if (overrun_a !== 1'b0) begin
      bad++;
      $display("FAIL basic_overrun: got %b, required 0", overrun_a);
    end
  endtask

  task automatic test_hold_idle;
    logic [7:0] w;
    w = 8'h96;
    for (int i = 0; i < 5; i++) begin
      sin_a   = w[i];
      valid_a = 1'b1;
      tick();
    end
    valid_a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sin_a = k[0];
      tick();
    end
    total++;
    if (sin_ready_a !== 1'b1 || d_a !== 8'h4D || e_a !== 1'b0) begin
      bad++;
      $display("FAIL hold_idle: rdy=%b d=%h e=%b, required 1 4d 0", sin_ready_a, d_a, e_a);
    end
    for (int i = 5; i < 8; i++) begin
      sin_a   = w[i];
      valid_a = 1'b1;
      tick();
    end
    valid_a = 1'b0;
    total++;
    if (d_a !== w || sin_ready_a !== 1'b0 || e_a !== 1'b0) begin
      bad++;
      $display("FAIL hold_resume: d=%h rdy=%b e=%b, required %h 0 0", d_a, sin_ready_a, e_a, w);
    end
    for (int k = 0; k < 5; k++) tick();
  endtask

  task automatic test_toggle;
    logic [7:0] w;
    w = 8'h4D;
    shift_a(w, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      total++;
      if (d_a !== w || e_a !== (c == 2 || c == 3) || done_a !== (c == 4) || sin_ready_a !== (c == 5)) begin
        bad++;
        $display("FAIL toggle_seq T+%0d: d=%h e=%b done=%b rdy=%b, required d=%h e=%b done=%b rdy=%b",
                 c, d_a, e_a, done_a, sin_ready_a, w, (c == 2 || c == 3), (c == 4), (c == 5));
      end
      tick();
    end
  endtask

  task automatic test_overrun;
    for (int i = 0; i < 8; i++) begin
      sin_a   = 1'b1;
      valid_a = 1'b1;
      tick();
    end
    total++;
    if (d_a !== 8'hFF || sin_ready_a !== 1'b0 || overrun_a !== 1'b0) begin
      bad++;
      $display("FAIL ovr_first: d=%h rdy=%b ovr=%b, required ff 0 0", d_a, sin_ready_a, overrun_a);
    end
    // Keep offering ones through SETUP, STROBE, STROBE, HOLD: all dropped.
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (sin_ready_a !== 1'b1 || overrun_a !== 1'b1) begin
      bad++;
      $display("FAIL ovr_flag: rdy=%b ovr=%b, required 1 1", sin_ready_a, overrun_a);
    end
    for (int i = 0; i < 8; i++) begin
      sin_a   = 1'b0;
      valid_a = 1'b1;
      tick();
    end
    valid_a = 1'b0;
    total++;
    if (d_a !== 8'h00 || sin_ready_a !== 1'b0) begin
      bad++;
      $display("FAIL ovr_second: d=%h rdy=%b, required 00 0", d_a, sin_ready_a);
    end
    for (int k = 0; k < 6; k++) tick();
    total++;
    if (overrun_a !== 1'b1 || sin_ready_a !== 1'b1) begin
      bad++;
      $display("FAIL ovr_sticky: ovr=%b rdy=%b, required 1 1", overrun_a, sin_ready_a);
    end
  endtask

  task automatic test_reset_strobe;
    shift_a(8'hC3, 1'b0);
    tick();
    tick();
    total++;
    if (e_a !== 1'b1 || d_a !== 8'hC3) begin
      bad++;
      $display("FAIL rs_strobe2: e=%b d=%h, required 1 c3", e_a, d_a);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if (e_a !== 1'b0 || d_a !== 8'h00 || done_a !== 1'b0 || overrun_a !== 1'b0) begin
      bad++;
      $display("FAIL rs_abort: e=%b d=%h done=%b ovr=%b, required 0 00 0 0", e_a, d_a, done_a, overrun_a);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (done_a !== 1'b0 || e_a !== 1'b0 || sin_ready_a !== 1'b1) begin
        bad++;
        $display("FAIL rs_after cycle %0d: done=%b e=%b rdy=%b, required 0 0 1", k, done_a, e_a, sin_ready_a);
      end
    end
  endtask

  task automatic test_small;
    logic [3:0] w;
    w = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      sin_b   = w[i];
      valid_b = 1'b1;
      tick();
    end
    valid_b = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (d_b !== 4'hB || e_b !== (c == 2) || done_b !== (c == 3) || sin_ready_b !== (c == 4)) begin
        bad++;
        $display("FAIL small_seq T+%0d: d=%h e=%b done=%b rdy=%b, required d=b e=%b done=%b rdy=%b",
                 c, d_b, e_b, done_b, sin_ready_b, (c == 2), (c == 3), (c == 4));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_idle();
    test_toggle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    test_overrun();
    test_reset_strobe();
    test_small();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
